eip_redirect_unit: RTL and testbench

Parametrised architectural EIP register with redirect control for the writeback stage. Selects next EIP from the decode stage's sequential next-EIP or a writeback branch target. Evaluates a generalised N-flag branch condition and applies 16-bit operand-size truncation. On a taken redirect it runs a flush state machine that squashes decode updates for a configurable window, and keeps a saturating redirect counter.

---
 rtl/eip_pkg.sv | 24 ++
 rtl/eip_cond_eval.sv | 32 +++
 rtl/mux_nbit_2x1.sv | 23 ++
 rtl/eip_redirect_unit.sv | 157 +++++++++++++++
 tb/tb_eip_redirect_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/eip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eip_pkg
// Description : Shared types and constants for the EIP redirect unit.
//               Holds the redirect FSM state type and the condition-flag
//               bit positions used by the writeback condition vector.
// Revision    : 1.0 - initial release
// ============================================================================
package eip_pkg;

    // Redirect FSM: IDLE accepts updates, FLUSH squashes wrong-path updates.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } eip_state_e;

    // Bit positions inside the NFLAG-wide flag/mask/expected vectors.
    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_SF = 2;
    localparam int FLAG_OF = 3;

endpackage : eip_pkg
`default_nettype wire

// File: rtl/eip_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : eip_cond_eval
// Description : Generalised branch-condition evaluator. Every flag whose mask
//               bit is set must equal its expected value; unmasked flags are
//               don't-care, so an all-zero mask is an unconditional branch.
//               Purely combinational.
// Ports       : mask_i     - flags the condition depends on
//               expected_i - required value per masked flag
//               flags_i    - current flag values
//               cond_met_o - condition satisfied
// Revision    : 1.0 - initial release
// ============================================================================
module eip_cond_eval #(
    parameter int NFLAG = 4
) (
    input  logic [NFLAG-1:0] mask_i,
    input  logic [NFLAG-1:0] expected_i,
    input  logic [NFLAG-1:0] flags_i,
    output logic             cond_met_o
);

    logic [NFLAG-1:0] flag_ok;

    for (genvar i = 0; i < NFLAG; i++) begin : g_flag
        assign flag_ok[i] = ~mask_i[i] | (flags_i[i] ~^ expected_i[i]);
    end

    assign cond_met_o = &flag_ok;

endmodule : eip_cond_eval
`default_nettype wire

// File: rtl/mux_nbit_2x1.sv
`default_nettype none
// ============================================================================
// Module      : mux_nbit_2x1
// Description : N-bit two-input multiplexer.
// Ports       : a_i   - input selected when sel_i = 0
//               b_i   - input selected when sel_i = 1
//               sel_i - select
//               y_o   - selected value
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nbit_2x1 #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sel_i,
    output logic [N-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule : mux_nbit_2x1
`default_nettype wire

// File: rtl/eip_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : eip_redirect_unit
// Description : Architectural EIP register with writeback redirect control.
//               Loads either the decode stage's sequential next EIP or a
//               writeback branch target (optionally truncated to 16 bits).
//               A taken redirect opens a FLUSH_CYC-cycle flush window during
//               which wrong-path decode/writeback inputs are ignored, and
//               bumps a saturating redirect counter.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               wb_*              - writeback valid, redirect, condition and
//                                   target candidates, 16-bit size override
//               de_v, de_eip_next - decode valid and sequential next EIP
//               fe_not_stall      - fetch not stalled
//               stat_clr          - clear redirect counter
//               eip               - architectural EIP
//               redirect          - one-cycle pulse after a taken redirect
//               flush             - flush window active
//               redirect_cnt      - saturating taken-redirect count
// Revision    : 1.0 - initial release
// ============================================================================
module eip_redirect_unit
    import eip_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NFLAG     = 4,
    parameter int                FLUSH_CYC = 2,
    parameter logic [ADDR_W-1:0] RESET_EIP = 32'h0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_v,
    input  logic              wb_eip_change,
    input  logic [NFLAG-1:0]  wb_cond_mask,
    input  logic [NFLAG-1:0]  wb_cond_expected,
    input  logic [NFLAG-1:0]  wb_flags,
    input  logic [ADDR_W-1:0] wb_tgt_a,
    input  logic [ADDR_W-1:0] wb_tgt_b,
    input  logic              wb_tgt_sel,
    input  logic              wb_size16,
    input  logic              de_v,
    input  logic [ADDR_W-1:0] de_eip_next,
    input  logic              fe_not_stall,
    input  logic              stat_clr,
    output logic [ADDR_W-1:0] eip,
    output logic              redirect,
    output logic              flush,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam int FCNT_W = $clog2(FLUSH_CYC + 1);
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYC - 1);

    eip_state_e        state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] eip_q, eip_d;
    logic              redirect_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cond_met;
    logic [ADDR_W-1:0] tgt_mux;
    logic [ADDR_W-1:0] tgt;
    logic              idle;
    logic              taken;
    logic              de_upd;

    eip_cond_eval #(
        .NFLAG (NFLAG)
    ) u_cond (
        .mask_i     (wb_cond_mask),
        .expected_i (wb_cond_expected),
        .flags_i    (wb_flags),
        .cond_met_o (cond_met)
    );

    mux_nbit_2x1 #(
        .N (ADDR_W)
    ) u_tgt_mux (
        .a_i   (wb_tgt_a),
        .b_i   (wb_tgt_b),
        .sel_i (wb_tgt_sel),
        .y_o   (tgt_mux)
    );

    // 16-bit operand size wraps the target into the low 64 KiB.
    assign tgt = wb_size16 ? {{(ADDR_W-16){1'b0}}, tgt_mux[15:0]} : tgt_mux;

    // Everything arriving while FLUSH is active is wrong-path.
    assign idle   = (state_q == IDLE);
    assign taken  = wb_v & wb_eip_change & cond_met & idle;
    assign de_upd = de_v & fe_not_stall & idle;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        eip_d   = eip_q;
        cnt_d   = cnt_q;

        // Writeback target wins over a simultaneous decode update.
        if (taken) begin
            eip_d = tgt;
        end else if (de_upd) begin
            eip_d = de_eip_next;
        end

        case (state_q)
            IDLE: begin
                if (taken) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase

        // Clear beats a coincident increment.
        if (stat_clr) begin
            cnt_d = '0;
        end else if (taken && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fcnt_q     <= '0;
            eip_q      <= RESET_EIP;
            redirect_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            eip_q      <= eip_d;
            redirect_q <= taken;
            cnt_q      <= cnt_d;
        end
    end

    assign eip          = eip_q;
    assign redirect     = redirect_q;
    assign flush        = (state_q == FLUSH);
    assign redirect_cnt = cnt_q;

endmodule : eip_redirect_unit
`default_nettype wire

// File: tb/tb_eip_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_eip_redirect_unit
// Description : Scoreboard bench for eip_redirect_unit. The driver applies
//               one cycle of stimulus at a time, advances an abstract model
//               (EIP value, remaining flush cycles, counter) and queues the
//               expected post-edge outputs; an independent monitor samples
//               the DUT after each rising edge and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eip_redirect_unit;

    localparam int          ADDR_W    = 32;
    localparam int          NFLAG     = 4;
    localparam int          FLUSH_CYC = 2;
    localparam int          CNT_W     = 8;   // small so saturation is reachable
    localparam logic [31:0] RST_EIP   = 32'h0000_FFF0;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;
    localparam int          ZF        = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_v, wb_eip_change, wb_tgt_sel, wb_size16;
    logic [NFLAG-1:0]  wb_cond_mask, wb_cond_expected, wb_flags;
    logic [ADDR_W-1:0] wb_tgt_a, wb_tgt_b, de_eip_next;
    logic              de_v, fe_not_stall, stat_clr;
    logic [ADDR_W-1:0] eip;
    logic              redirect, flush;
    logic [CNT_W-1:0]  redirect_cnt;

    eip_redirect_unit #(
        .ADDR_W    (ADDR_W),
        .NFLAG     (NFLAG),
        .FLUSH_CYC (FLUSH_CYC),
        .RESET_EIP (RST_EIP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wb_v             (wb_v),
        .wb_eip_change    (wb_eip_change),
        .wb_cond_mask     (wb_cond_mask),
        .wb_cond_expected (wb_cond_expected),
        .wb_flags         (wb_flags),
        .wb_tgt_a         (wb_tgt_a),
        .wb_tgt_b         (wb_tgt_b),
        .wb_tgt_sel       (wb_tgt_sel),
        .wb_size16        (wb_size16),
        .de_v             (de_v),
        .de_eip_next      (de_eip_next),
        .fe_not_stall     (fe_not_stall),
        .stat_clr         (stat_clr),
        .eip              (eip),
        .redirect         (redirect),
        .flush            (flush),
        .redirect_cnt     (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] eip;
        logic        red;
        logic        fl;
        int          cnt;
        int          idx;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;

    // Abstract reference state
    logic [31:0] m_eip;
    int          m_rem;   // flush cycles still to come
    logic        m_red;
    int          m_cnt;

    task automatic check(input string name, input int idx,
                         input longint act, input longint expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, idx, act, expv);
        end
    endtask

    // Monitor: one queued expectation per rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("eip",          e.idx, longint'(eip),          longint'(e.eip));
            check("redirect",     e.idx, longint'(redirect),     longint'(e.red));
            check("flush",        e.idx, longint'(flush),        longint'(e.fl));
            check("redirect_cnt", e.idx, longint'(redirect_cnt), longint'(e.cnt));
        end
    end

    // Model one clock edge from the current inputs, queue the result, then
    // move to the next falling edge where new inputs are applied.
    task automatic tick();
        exp_t        e;
        bit          met, taken, idle;
        logic [31:0] t;
        if (!rst_n) begin
            m_eip = RST_EIP;
            m_rem = 0;
            m_red = 1'b0;
            m_cnt = 0;
        end else begin
            idle = (m_rem == 0);
            met  = 1'b1;
            for (int i = 0; i < NFLAG; i++)
                if (wb_cond_mask[i] && (wb_flags[i] != wb_cond_expected[i])) met = 1'b0;
            taken = wb_v && wb_eip_change && met && idle;
            t = wb_tgt_sel ? wb_tgt_b : wb_tgt_a;
            if (wb_size16) t = t % 32'h1_0000;
            if (taken)                           m_eip = t;
            else if (de_v && fe_not_stall && idle) m_eip = de_eip_next;
            if (taken)          m_rem = FLUSH_CYC;
            else if (m_rem > 0) m_rem = m_rem - 1;
            m_red = taken;
            if (stat_clr)                     m_cnt = 0;
            else if (taken && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
        e.eip = m_eip; e.red = m_red; e.fl = (m_rem > 0); e.cnt = m_cnt; e.idx = n_cyc;
        sb.push_back(e);
        n_cyc++;
        @(negedge clk);
    endtask

    task automatic quiet();
        rst_n = 1'b1; wb_v = 1'b0; wb_eip_change = 1'b0; wb_tgt_sel = 1'b0;
        wb_size16 = 1'b0; wb_cond_mask = '0; wb_cond_expected = '0; wb_flags = '0;
        wb_tgt_a = '0; wb_tgt_b = '0; de_v = 1'b0; de_eip_next = '0;
        fe_not_stall = 1'b1; stat_clr = 1'b0;
    endtask

    task automatic branch(input logic [31:0] tgt);
        wb_v = 1'b1; wb_eip_change = 1'b1; wb_cond_mask = '0;
        wb_tgt_sel = 1'b0; wb_tgt_a = tgt; wb_size16 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        @(negedge clk);
        rst_n = 1'b0; tick(); tick();

        // Sequential decode update
        quiet(); de_v = 1'b1; de_eip_next = 32'h1004; tick();
        quiet(); tick();

        // Unconditional, candidate b, 16-bit truncation -> 0x5678
        quiet(); wb_v = 1'b1; wb_eip_change = 1'b1; wb_tgt_sel = 1'b1;
        wb_tgt_b = 32'h1234_5678; wb_tgt_a = 32'hDEAD_BEEF; wb_size16 = 1'b1; tick();
        quiet(); repeat (3) tick();

        // Conditional on ZF=1: first ZF=0 (falls through), then ZF=1 (taken)
        quiet(); wb_v = 1'b1; wb_eip_change = 1'b1; wb_cond_mask[ZF] = 1'b1;
        wb_cond_expected[ZF] = 1'b1; wb_flags[ZF] = 1'b0; wb_tgt_a = 32'h0000_9000;
        de_v = 1'b1; de_eip_next = 32'h1010; tick();
        wb_flags[ZF] = 1'b1; tick();
        quiet(); repeat (3) tick();

        // Simultaneous taken and decode update, then wrong-path traffic
        quiet(); branch(32'h2000); de_v = 1'b1; de_eip_next = 32'h1008; tick();
        quiet(); branch(32'h4000); de_v = 1'b1; de_eip_next = 32'h3000; tick(); tick();
        quiet(); de_v = 1'b1; de_eip_next = 32'h2004; tick();

        // Reset in the middle of a flush window
        quiet(); branch(32'h5000); tick();
        quiet(); rst_n = 1'b0; tick();
        quiet(); repeat (2) tick();

        // Drive the counter into saturation and one step beyond
        for (int k = 0; k < CNT_MAX + 2; k++) begin
            quiet(); branch(32'h100 + k); tick();
            quiet(); repeat (FLUSH_CYC) tick();
        end
        // Clear coincident with a taken redirect
        quiet(); branch(32'h6000); stat_clr = 1'b1; tick();
        quiet(); repeat (3) tick();

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            rst_n            = ($urandom_range(0, 99) != 0);
            wb_v             = $urandom_range(0, 1);
            wb_eip_change    = ($urandom_range(0, 2) != 0);
            wb_cond_mask     = ($urandom_range(0, 2) == 0) ? '0 : NFLAG'($urandom);
            wb_cond_expected = NFLAG'($urandom);
            wb_flags         = NFLAG'($urandom);
            wb_tgt_a         = $urandom;
            wb_tgt_b         = $urandom;
            wb_tgt_sel       = $urandom_range(0, 1);
            wb_size16        = $urandom_range(0, 1);
            de_v             = $urandom_range(0, 1);
            de_eip_next      = $urandom;
            fe_not_stall     = ($urandom_range(0, 3) != 0);
            stat_clr         = ($urandom_range(0, 29) == 0);
            tick();
        end

        quiet();
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_eip_redirect_unit
`default_nettype wire
